// File: rtl/rx_cmd_parser.sv
`default_nettype none
// rx_cmd_parser: assembles UART bytes into RGB PWM duty-register write commands. Rev 1.0
// Define RX_CMD_CHECKSUM_EN for the 4-byte frame carrying an XOR checksum byte.
module rx_cmd_parser #(
  parameter logic [7:0] SOF_BYTE      = 8'hA5,
  parameter int         NUM_CH        = 3,
  parameter int         TIMEOUT_TICKS = 640
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       baud_rate_oversample,
  input  logic       rx_done,
  input  logic [7:0] data_recived,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam logic [8:0]  NUM_CH_L = 9'(NUM_CH);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
`ifdef RX_CMD_CHECKSUM_EN
    , CHK = 2'd3
`endif
  } state_t;

  state_t      state, state_nxt;
  logic        rx_done_d;
  logic        byte_rx;
  logic [1:0]  addr_q, addr_nxt;
  logic        bad_addr, bad_nxt;
  logic [15:0] to_cnt, to_nxt;
  logic        wr_fire, err_fire;
  logic [7:0]  fin_data;
`ifdef RX_CMD_CHECKSUM_EN
  logic [7:0]  data_q, data_nxt;
  logic [7:0]  chk_acc, chk_nxt;
`endif

  // Rising edge of the PHY level flag gives exactly one acceptance per byte.
  assign byte_rx = rx_done & ~rx_done_d;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    bad_nxt   = bad_addr;
    to_nxt    = to_cnt;
    wr_fire   = 1'b0;
    err_fire  = 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
    data_nxt  = data_q;
    chk_nxt   = chk_acc;
    fin_data  = data_q;
`else
    fin_data  = data_recived;
`endif

    // An arriving byte takes priority over the timeout terminal count.
    if (state == IDLE || byte_rx) begin
      to_nxt = 16'd0;
    end else if (baud_rate_oversample) begin
      if (to_cnt == TO_LAST) begin
        err_fire  = 1'b1;
        state_nxt = IDLE;
        to_nxt    = 16'd0;
      end else begin
        to_nxt = to_cnt + 16'd1;
      end
    end

    if (byte_rx) begin
      case (state)
        IDLE: begin
          if (data_recived == SOF_BYTE) begin
            state_nxt = ADDR;
`ifdef RX_CMD_CHECKSUM_EN
            chk_nxt   = SOF_BYTE;
`endif
          end
        end
        ADDR: begin
          addr_nxt  = data_recived[1:0];
          state_nxt = DATA;
          if ({1'b0, data_recived} >= NUM_CH_L) bad_nxt = 1'b1;
`ifdef RX_CMD_CHECKSUM_EN
          chk_nxt   = chk_acc ^ data_recived;
`endif
        end
        DATA: begin
`ifdef RX_CMD_CHECKSUM_EN
          data_nxt  = data_recived;
          chk_nxt   = chk_acc ^ data_recived;
          state_nxt = CHK;
`else
          state_nxt = IDLE;
          if (bad_addr) err_fire = 1'b1;
          else          wr_fire  = 1'b1;
`endif
        end
`ifdef RX_CMD_CHECKSUM_EN
        CHK: begin
          state_nxt = IDLE;
          if (!bad_addr && data_recived == chk_acc) wr_fire  = 1'b1;
          else                                      err_fire = 1'b1;
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt == IDLE) bad_nxt = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_done_d <= 1'b0;
      addr_q    <= 2'd0;
      bad_addr  <= 1'b0;
      to_cnt    <= 16'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 2'd0;
      wr_data   <= 8'd0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
      busy      <= 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
      data_q    <= 8'd0;
      chk_acc   <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      rx_done_d <= rx_done;
      addr_q    <= addr_nxt;
      bad_addr  <= bad_nxt;
      to_cnt    <= to_nxt;
      wr_en     <= wr_fire;
      frame_err <= err_fire;
      busy      <= (state != IDLE);
`ifdef RX_CMD_CHECKSUM_EN
      data_q    <= data_nxt;
      chk_acc   <= chk_nxt;
`endif
      if (wr_fire) begin
        wr_addr <= addr_q;
        wr_data <= fin_data;
      end
      if (err_fire && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_cmd_parser.sv
`default_nettype none
// tb_rx_cmd_parser: randomized + directed bench against a frame-level reference model.
module tb_rx_cmd_parser;

  localparam logic [7:0] SOF = 8'hA5;
  localparam int NUM_CH  = 3;
  localparam int TIMEOUT = 640;
`ifdef RX_CMD_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rx_done;
  logic [7:0] data;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  rx_cmd_parser #(.SOF_BYTE(SOF), .NUM_CH(NUM_CH), .TIMEOUT_TICKS(TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .baud_rate_oversample(tick),
    .rx_done(rx_done), .data_recived(data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is just the list of bytes collected since SOF.
  logic [7:0] fq[$];
  int m_wr = 0, m_err = 0, m_errcnt = 0;
  logic [1:0] m_addr = 2'd0;
  logic [7:0] m_data = 8'd0;

  task automatic note_err();
    m_err++;
    if (m_errcnt < 255) m_errcnt++;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ew, output bit ee);
    bit ok;
    ew = 1'b0;
    ee = 1'b0;
    if (fq.size() == 0 && b != SOF) return;
    fq.push_back(b);
    if (fq.size() == FLEN) begin
      ok = (fq[1] < NUM_CH);
`ifdef RX_CMD_CHECKSUM_EN
      ok = ok && (fq[3] == (fq[0] ^ fq[1] ^ fq[2]));
`endif
      if (ok) begin
        ew = 1'b1;
        m_wr++;
        m_addr = fq[1][1:0];
        m_data = fq[2];
      end else begin
        ee = 1'b1;
        note_err();
      end
      fq.delete();
    end
  endtask

  // Monitor counts output pulses, sampled on the falling edge.
  int mon_wr = 0, mon_err = 0;
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (wr_en) mon_wr++;
      if (frame_err) mon_err++;
    end
  end

  task automatic check_counts(input string tag);
    check_val({tag, "_wr_count"}, mon_wr, m_wr);
    check_val({tag, "_err_count"}, mon_err, m_err);
    check_val({tag, "_err_cnt"}, err_cnt, m_errcnt);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    bit ew, ee;
    model_byte(b, ew, ee);
    @(negedge sys_clk);
    data = b;
    rx_done = 1'b1;
    @(negedge sys_clk);
    check_val("wr_en_latency", wr_en, ew);
    check_val("frame_err_latency", frame_err, ee);
    if (ew) begin
      check_val("wr_addr", wr_addr, m_addr);
      check_val("wr_data", wr_data, m_data);
    end
    repeat (hold - 1) @(negedge sys_clk);
    rx_done = 1'b0;
    @(negedge sys_clk);
    check_counts("byte");
  endtask

  task automatic send_rest(input logic [7:0] a, input logic [7:0] d, input bit corrupt, input int hold);
    send_byte(a, hold);
    send_byte(d, hold);
`ifdef RX_CMD_CHECKSUM_EN
    send_byte((SOF ^ a ^ d) ^ (corrupt ? 8'h01 : 8'h00), hold);
`else
    if (corrupt) n_tests = n_tests;
`endif
  endtask

  task automatic idle_ticks(input int n);
    bit armed;
    armed = (fq.size() != 0);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      tick = 1'b1;
      @(negedge sys_clk);
      tick = 1'b0;
      if (armed && i == TIMEOUT - 2) check_val("timeout_not_early", frame_err, 0);
      if (armed && i == TIMEOUT - 1) check_val("timeout_pulse", frame_err, 1);
    end
    if (armed && n >= TIMEOUT) begin
      fq.delete();
      note_err();
    end
    @(negedge sys_clk);
    check_counts("ticks");
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_wr_data"}, wr_data, 0);
    check_val({tag, "_frame_err"}, frame_err, 0);
    check_val({tag, "_err_cnt"}, err_cnt, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, d;
    bit ew, ee;
    rst_n = 1'b0; tick = 1'b0; rx_done = 1'b0; data = 8'd0;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Good frame, then bad checksum, bad address and a recovery frame.
    send_byte(SOF, 2); send_rest(8'h01, 8'h80, 1'b0, 2);
    check_val("busy_after_good", busy, 0);
    send_byte(SOF, 2); send_byte(8'h02, 2); send_byte(8'h10, 2); send_byte(8'h00, 2);
    check_val("busy_after_bad", busy, 0);
    send_byte(SOF, 1); send_byte(8'h03, 1); send_byte(8'h55, 1); send_byte(8'hF3, 1);
    send_byte(SOF, 1); send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h5A, 1);

    // Timeout, then stray bytes in IDLE.
    send_byte(SOF, 2);
    repeat (3) @(negedge sys_clk);
    check_val("busy_mid_frame", busy, 1);
    idle_ticks(700);
    check_val("busy_after_timeout", busy, 0);
    send_byte(8'h00, 2); send_byte(8'h12, 2);

    // One tick short of the timeout still completes the frame.
    send_byte(SOF, 2); idle_ticks(TIMEOUT - 1); send_rest(8'h02, 8'h7F, 1'b0, 2);

    // Long rx_done holds, reset mid-frame, rx_done high at reset release.
    send_byte(SOF, 40); send_byte(8'h01, 40);
    @(negedge sys_clk);
    rst_n = 1'b0; data = SOF; rx_done = 1'b1;
    repeat (2) @(negedge sys_clk);
    fq.delete(); m_errcnt = 0;
    check_idle_outputs("midframe_reset");
    rst_n = 1'b1;
    model_byte(SOF, ew, ee);
    repeat (4) @(negedge sys_clk);
    rx_done = 1'b0;
    @(negedge sys_clk);
    check_val("busy_after_held_sof", busy, 1);
    send_rest(8'h00, 8'h33, 1'b0, 3);
    check_val("post_reset_addr", wr_addr, 0);
    check_val("post_reset_data", wr_data, 8'h33);

    // Randomized frames, stray bytes, short and timeout-length gaps.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'($urandom), $urandom_range(1, 6));
      end else begin
        send_byte(SOF, $urandom_range(1, 6));
        if ($urandom_range(0, 15) == 0) idle_ticks($urandom_range(TIMEOUT - 10, TIMEOUT + 20));
        else                            idle_ticks($urandom_range(0, 20));
        a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
        d = 8'($urandom);
        send_rest(a, d, ($urandom_range(0, 3) == 0), $urandom_range(1, 6));
      end
    end

    // Saturate the error counter.
    for (int k = 0; k < 300; k++) begin
      send_byte(SOF, 1);
      send_byte(8'h03, 1);
      for (int j = 2; j < FLEN; j++) send_byte(8'h00, 1);
    end
    check_val("err_cnt_saturated", err_cnt, 8'hFF);
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_cmd_parser.md
# rx_cmd_parser

Byte-level command controller sitting directly behind the UART receive PHY. It consumes each received byte (`rx_done` / `data_recived`) and assembles fixed-length command frames: SOF, channel address, duty and optional checksum. It issues single-cycle write strobes into the RGB PWM duty registers. It also enforces an inter-byte timeout and reports malformed frames.

## Interface
Parameters:
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.
- `NUM_CH`, default 3: number of valid channel addresses (0..NUM_CH-1; 0=R, 1=G, 2=B).
- `TIMEOUT_TICKS`, default 640: `baud_rate_oversample` ticks allowed between bytes (4 byte times at 16x). Range 1..65535.

Ports:
- `sys_clk` in 1: system clock. All logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `baud_rate_oversample` in 1: one-`sys_clk` tick enable at 16x baud.
- `rx_done` in 1: PHY byte-complete flag. Level; may stay high for many `sys_clk` cycles.
- `data_recived` in 8: PHY received byte. Stable while `rx_done` is high.
- `wr_en` out 1: one-cycle duty-register write strobe.
- `wr_addr` out 2: channel address, valid with `wr_en`.
- `wr_data` out 8: duty value, valid with `wr_en`.
- `frame_err` out 1: one-cycle pulse on any discarded frame.
- `err_cnt` out 8: saturating count of `frame_err` pulses.
- `busy` out 1: high when state is not IDLE.

## Operation
- Byte acceptance:
  - Register `rx_done` into `rx_done_d`.
  - `byte_rx` = `rx_done & ~rx_done_d`.
  - Exactly one acceptance per PHY byte, regardless of how long `rx_done` stays high.
- States: IDLE, ADDR, DATA, CHK. CHK exists only with the checksum enabled (see Configuration).
- IDLE:
  - `byte_rx` with `data_recived==SOF_BYTE` → ADDR; load `chk_acc=SOF_BYTE`.
  - Any other byte is dropped silently, with no error.
- ADDR:
  - `byte_rx` → latch `addr_q=data_recived[1:0]`, XOR the byte into `chk_acc`, → DATA.
  - If `data_recived >= NUM_CH`, set the sticky `bad_addr` flag. The frame is still consumed to its end.
- DATA:
  - `byte_rx` → latch `data_q`, XOR into `chk_acc`.
  - Then → CHK when the checksum is enabled.
  - Otherwise → IDLE, completing the frame.
- CHK: `byte_rx` → IDLE, completing the frame. The checksum passes when `data_recived == chk_acc`.
- Frame completion:
  - Good frame (`bad_addr==0` and checksum passes or is disabled): `wr_en=1`, `wr_addr=addr_q`, `wr_data` = final duty.
  - Otherwise: `frame_err=1`.
  - `bad_addr` clears on every entry to IDLE.
- SOF_BYTE received mid-frame is treated as payload. There is no resync.
- Timeout:
  - `to_cnt` (16 bits) clears on every `byte_rx` and while in IDLE.
  - Otherwise it increments on each `baud_rate_oversample` tick.
  - Reaching `TIMEOUT_TICKS` → `frame_err` pulse, → IDLE, `to_cnt` cleared.
- `err_cnt` increments on each `frame_err` and saturates at 255.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `frame_err=0`, `err_cnt=0`, `busy=0`. State IDLE; all internal registers 0.
- Reset mid-frame abandons the partial frame with no `frame_err` and no write.
- Latency: `wr_en` / `frame_err` are registered. They go high in the cycle after the `sys_clk` edge at which the final `byte_rx` is seen, and stay high for exactly 1 cycle.
- `wr_addr` / `wr_data` hold their value until the next write.
- `busy` is registered from state. It rises one cycle after the SOF is accepted.
- Simultaneous events:
  - `byte_rx` in the same cycle as the timeout terminal count: the byte wins and the counter clears.
  - `byte_rx` while a `wr_en` / `frame_err` pulse is being output: processed normally.
- `rx_done` already high at reset release: `rx_done_d` resets to 0, so one byte is accepted. In IDLE it is dropped unless it is the SOF.
- Back-to-back frames need no idle gap.

## Configuration
- `RX_CMD_CHECKSUM_EN` defined:
  - 4-byte frame; CHK state present.
  - Checksum = SOF^ADDR^DATA.
  - A mismatch gives `frame_err` and no write.
- Not defined:
  - 3-byte frame; CHK state and `chk_acc` removed.
  - The write occurs on the DATA byte.

## Test plan
- Checksum on, bytes A5, 01, 80, 24 → single `wr_en` pulse with `wr_addr=1`, `wr_data=8'h80`; `frame_err=0`, `err_cnt=0`.
- Checksum on, bytes A5, 02, 10, 00 (bad checksum) → no `wr_en`; one `frame_err`; `err_cnt=1`; `busy` low afterwards.
- Bytes A5, 03, 55, F3 (address out of range, checksum valid) → no write; `frame_err`; the next good frame A5, 00, FF, 5A writes `addr=0`, `data=FF`.
- A5, then 700 oversample ticks idle → `frame_err` at tick 640; state IDLE. Stray bytes 00, 12 in IDLE → no error, `err_cnt` unchanged.
- Hold `rx_done` high for 40 `sys_clk` cycles per byte, then assert `rst_n=0` after the ADDR byte → each byte is counted once; after reset all outputs are 0, and a following complete frame writes correctly.
- Checksum off: A5, 02, 7F → `wr_en` with `addr=2`, `data=7F` one cycle after the third `byte_rx`. Drive 300 consecutive `frame_err` events → `err_cnt` saturates at 255.
